itr_ctrl: RTL and testbench

//  Interrupt controller and scheduler for the processor core's single itr input.

---
 rtl/itr_ctrl.sv | 147 ++++++++++++++
 tb/tb_itr_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/itr_ctrl.sv
// Interrupt controller for a single-input core: edge-latches NSRC request lines, masks them,
// fires a one-cycle itr pulse for the lowest pending source and waits for an I/O-port acknowledge.
module itr_ctrl #(
  parameter int NSRC   = 4,
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int ACKADR = 0,
  parameter int MSKADR = 1,
  parameter int STSADR = 0,
  parameter int MSKRST = 0,
  parameter int MINGAP = 2,
  parameter int TMOUT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           irq,
  input  logic [NUBITS-1:0]         data_out,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic                      out_en,
  input  logic [$clog2(NUIOIN)-1:0] addr_in,
  input  logic                      req_in,
  output logic [NUBITS-1:0]         io_data,
  output logic                      itr,
  output logic                      busy
);

  localparam int AOW = $clog2(NUIOOU);
  localparam int AIW = $clog2(NUIOIN);
  localparam int GW  = (MINGAP > 1) ? $clog2(MINGAP) : 1;
  localparam int TW  = (TMOUT > 1) ? $clog2(TMOUT) : 1;
  localparam logic [GW-1:0] GLAST = GW'((MINGAP > 0) ? MINGAP - 1 : 0);
  localparam logic [TW-1:0] TLAST = TW'((TMOUT > 0) ? TMOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, FIRE, BUSY, GAP} state_t;

  state_t          state_reg, state_next;
  logic [NSRC-1:0] irq_s, irq_d, rise_reg;
  logic [NSRC-1:0] pend_reg, mask_reg, eligible, clr;
  logic [3:0]      cur_src_reg, cur_src_next, low_idx;
  logic            itr_reg, itr_next;
  logic            tmo_reg, tmo_set;
  logic [GW-1:0]   gcnt_reg, gcnt_next;
  logic [TW-1:0]   tcnt_reg, tcnt_next;
  logic            ack, msk_wr, sts_rd;
  logic            unused_data;

  assign ack         = out_en && (addr_out == AOW'(ACKADR));
  assign msk_wr      = out_en && (addr_out == AOW'(MSKADR));
  assign sts_rd      = req_in && (addr_in == AIW'(STSADR));
  assign eligible    = pend_reg & mask_reg;
  assign unused_data = ^data_out[NUBITS-1:NSRC];

  // Priority: lowest index wins, so scan from the top and let lower bits overwrite.
  always_comb begin
    low_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_src_next = cur_src_reg;
    itr_next     = 1'b0;
    clr          = '0;
    tmo_set      = 1'b0;
    gcnt_next    = gcnt_reg;
    tcnt_next    = tcnt_reg;
    case (state_reg)
      IDLE: begin
        if (|eligible) begin
          cur_src_next = low_idx;
          clr          = NSRC'(1) << low_idx;
          itr_next     = 1'b1;
          state_next   = FIRE;
        end
      end
      FIRE: begin
        tcnt_next  = '0;
        state_next = BUSY;
      end
      BUSY: begin
        if (ack) begin
          gcnt_next  = '0;
          state_next = (MINGAP > 0) ? GAP : IDLE;
        end else if ((TMOUT > 0) && (tcnt_reg == TLAST)) begin
          tmo_set    = 1'b1;
          gcnt_next  = '0;
          state_next = (MINGAP > 0) ? GAP : IDLE;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end
      GAP: begin
        if (gcnt_reg == GLAST) state_next = IDLE;
        else                   gcnt_next  = gcnt_reg + GW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // rise is registered, so a new edge reaches pend two edges after it is first sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      irq_s       <= '0;
      irq_d       <= '0;
      rise_reg    <= '0;
      pend_reg    <= '0;
      mask_reg    <= NSRC'(MSKRST);
      cur_src_reg <= '0;
      itr_reg     <= 1'b0;
      tmo_reg     <= 1'b0;
      gcnt_reg    <= '0;
      tcnt_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      irq_s       <= irq;
      irq_d       <= irq_s;
      rise_reg    <= irq_s & ~irq_d;
      pend_reg    <= (pend_reg & ~clr) | rise_reg;
      if (msk_wr) mask_reg <= data_out[NSRC-1:0];
      cur_src_reg <= cur_src_next;
      itr_reg     <= itr_next;
      if (tmo_set)     tmo_reg <= 1'b1;
      else if (sts_rd) tmo_reg <= 1'b0;
      gcnt_reg    <= gcnt_next;
      tcnt_reg    <= tcnt_next;
    end
  end

  assign itr  = itr_reg;
  assign busy = (state_reg != IDLE);

  always_comb begin
    io_data = '0;
    if (addr_in == AIW'(STSADR)) begin
      io_data[3:0]         = cur_src_reg;
      io_data[4]           = busy;
      io_data[5]           = tmo_reg;
      io_data[6]           = |eligible;
      io_data[16 +: NSRC]  = pend_reg;
    end
  end

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl: a per-cycle vector table for the main flows,
// then hand-written sequences for asynchronous reset and port decoding.
module tb_itr_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic [31:0] data_out;
  logic [2:0]  addr_out;
  logic        out_en;
  logic [2:0]  addr_in;
  logic        req_in;
  logic [31:0] io_data;
  logic        itr;
  logic        busy;

  int total = 0;
  int bad   = 0;

  itr_ctrl #(
    .NSRC(4), .NUBITS(32), .NUIOIN(8), .NUIOOU(8), .ACKADR(0), .MSKADR(1),
    .STSADR(0), .MSKRST(0), .MINGAP(2), .TMOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .data_out(data_out), .addr_out(addr_out),
    .out_en(out_en), .addr_in(addr_in), .req_in(req_in), .io_data(io_data),
    .itr(itr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        wr;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic        exp_itr;
    logic        exp_busy;
    logic [31:0] exp_io;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [3:0] i, input logic w, input logic [2:0] a, input logic [31:0] d,
                   input logic r, input logic ei, input logic eb, input logic [31:0] eio);
    vec_t t;
    t = '{i, w, a, d, r, ei, eb, eio};
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] i, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic r);
    irq = i; out_en = w; addr_out = a; data_out = d; req_in = r;
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b0; irq = '0; data_out = '0; addr_out = '0; out_en = 1'b0; addr_in = '0; req_in = 1'b0;

    // T1: mask all, pulse irq[2] for three cycles; itr after the fourth edge
    v(4'h0, 1, 1, 32'hF, 0, 0, 0, 32'h0);
    v(4'h4, 0, 0, 0, 0, 0, 0, 32'h0);
    v(4'h4, 0, 0, 0, 0, 0, 0, 32'h0);
    v(4'h4, 0, 0, 0, 0, 0, 0, 32'h0004_0040);
    v(4'h0, 0, 0, 0, 0, 1, 1, 32'h0000_0012);
    v(4'h0, 0, 0, 0, 0, 0, 1, 32'h0000_0012);
    // T2: ack, two gap cycles, idle on the third edge
    v(4'h0, 1, 0, 0, 0, 0, 1, 32'h0000_0012);
    v(4'h0, 0, 0, 0, 0, 0, 1, 32'h0000_0012);
    v(4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0002);
    v(4'h0, 1, 0, 0, 1, 0, 0, 32'h0000_0002);
    // T3: irq[3] and irq[1] together
    v(4'hA, 0, 0, 0, 0, 0, 0, 32'h0000_0002);
    v(4'hA, 0, 0, 0, 0, 0, 0, 32'h0000_0002);
    v(4'hA, 0, 0, 0, 0, 0, 0, 32'h000A_0042);
    v(4'hA, 0, 0, 0, 0, 1, 1, 32'h0008_0051);
    v(4'hA, 0, 0, 0, 0, 0, 1, 32'h0008_0051);
    v(4'hA, 1, 0, 0, 0, 0, 1, 32'h0008_0051);
    v(4'hA, 0, 0, 0, 0, 0, 1, 32'h0008_0051);
    v(4'hA, 0, 0, 0, 0, 0, 0, 32'h0008_0041);
    v(4'hA, 0, 0, 0, 0, 1, 1, 32'h0000_0013);
    v(4'hA, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    v(4'hA, 1, 0, 0, 0, 0, 1, 32'h0000_0013);
    v(4'h0, 0, 0, 0, 0, 0, 1, 32'h0000_0013);
    v(4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0003);
    // T4: masked source latches pend, fires once unmasked
    v(4'h0, 1, 1, 32'h0, 0, 0, 0, 32'h0000_0003);
    v(4'h1, 0, 0, 0, 0, 0, 0, 32'h0000_0003);
    v(4'h1, 0, 0, 0, 0, 0, 0, 32'h0000_0003);
    v(4'h1, 0, 0, 0, 0, 0, 0, 32'h0001_0003);
    v(4'h1, 0, 0, 0, 0, 0, 0, 32'h0001_0003);
    v(4'h1, 1, 1, 32'h1, 0, 0, 0, 32'h0001_0043);
    v(4'h1, 0, 0, 0, 0, 1, 1, 32'h0000_0010);
    v(4'h1, 0, 0, 0, 0, 0, 1, 32'h0000_0010);
    // T5: no ack, timeout after eight BUSY cycles, sticky tmo cleared by a status read
    for (int k = 0; k < 7; k++) v(4'h1, 0, 0, 0, 0, 0, 1, 32'h0000_0010);
    v(4'h1, 0, 0, 0, 0, 0, 1, 32'h0000_0030);
    v(4'h1, 0, 0, 0, 0, 0, 1, 32'h0000_0030);
    v(4'h1, 0, 0, 0, 0, 0, 0, 32'h0000_0020);
    v(4'h1, 0, 0, 0, 1, 0, 0, 32'h0000_0000);
    v(4'h0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);

    tick();
    tick();
    chk("reset.itr", {31'b0, itr}, 32'h0);
    chk("reset.busy", {31'b0, busy}, 32'h0);
    chk("reset.status", io_data, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].irq, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd);
      tick();
      $display("vec %0d: itr=%b busy=%b io=%h", i, itr, busy, io_data);
      chk($sformatf("v%0d.itr", i), {31'b0, itr}, {31'b0, tbl[i].exp_itr});
      chk($sformatf("v%0d.busy", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
      chk($sformatf("v%0d.status", i), io_data, tbl[i].exp_io);
    end

    // T6: fire with pend left at 1010, then asynchronous reset while itr is high
    drive(4'h0, 1, 1, 32'hF, 0);
    tick();
    drive(4'hB, 0, 0, 0, 0);
    tick(); tick(); tick();
    $display("t6 setup: io=%h", io_data);
    chk("t6.pend_set", io_data, 32'h000B_0040);
    tick();
    $display("t6 fire: itr=%b io=%h", itr, io_data);
    chk("t6.fire_itr", {31'b0, itr}, 32'h1);
    chk("t6.fire_status", io_data, 32'h000A_0050);
    addr_in = 3'd3;
    #1;
    chk("t6.other_port", io_data, 32'h0);
    addr_in = 3'd0;
    #2;
    rst = 1'b0;
    irq = 4'h0;
    #1;
    $display("t6 reset: itr=%b busy=%b io=%h", itr, busy, io_data);
    chk("t6.rst_itr", {31'b0, itr}, 32'h0);
    chk("t6.rst_busy", {31'b0, busy}, 32'h0);
    chk("t6.rst_status", io_data, 32'h0);
    tick();
    rst = 1'b1;
    drive(4'h0, 1, 1, 32'hF, 0);
    tick();
    drive(4'h0, 0, 0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (itr) seen = 1'b1;
    end
    $display("t6 quiet: itr_seen=%b io=%h", seen, io_data);
    chk("t6.no_spurious_itr", {31'b0, seen}, 32'h0);
    chk("t6.quiet_status", io_data, 32'h0);

    // fresh edge on irq[1] must fire after exactly four edges
    irq = 4'h2;
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      tick();
      if (itr) begin
        seen = 1'b1;
        n = k;
      end
    end
    $display("t6 new edge: itr after %0d edges io=%h", n, io_data);
    chk("t6.new_edge_seen", {31'b0, seen}, 32'h1);
    chk("t6.new_edge_latency", n, 32'd4);
    chk("t6.new_edge_status", io_data, 32'h0000_0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
